// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multicycle multiply/divide sequencer.
// The opcode constants are also consumed by the ALU decoder.
package hilo_muldiv_seq_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/hilo_iter_core.sv
// One iteration of the multicycle datapath: an unsigned shift-add multiply
// step or a restoring divide step over a shared 2*WIDTH-bit accumulator.
module hilo_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier}.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: {acc_hi, acc_lo} holds {partial remainder, dividend/quotient}.
    shifted = acc[2*WIDTH-1:WIDTH-1];
    // The restored remainder is below the divisor, so modulo-2^WIDTH is exact.
    diff    = shifted[WIDTH-1:0] - operand;

    if (!div_mode) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (shifted >= {1'b0, operand}) begin
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Multicycle MULT/DIV sequencer owning the architectural HI/LO pair.
// Results land in {hi, lo} on the edge that enters DONE.
module hilo_muldiv_seq
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       controle,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic               launch_mul;
  logic               launch_div;
  logic               div_by_zero;

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .div_mode (state == DIV),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  assign launch_mul  = (state == IDLE) && start && (controle == OP_MULT);
  assign launch_div  = (state == IDLE) && start && (controle == OP_DIV);
  assign div_by_zero = launch_div && (in2 == '0);
  assign busy        = (state == MUL) || (state == DIV);
  assign done        = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (launch_mul)       state_next = MUL;
        else if (div_by_zero) state_next = DONE;
        else if (launch_div)  state_next = DIV;
      end
      MUL, DIV: begin
        if (flush)          state_next = IDLE;
        else if (cnt == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: acc and operand carry no reset; they are always loaded on launch
  // before any cycle reads them.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (mt_hi) hi <= mt_data;
          if (mt_lo) lo <= mt_data;
          if (launch_mul) begin
            acc     <= {{WIDTH{1'b0}}, in2};
            operand <= in1;
            cnt     <= CNT_W'(WIDTH - 1);
          end else if (launch_div) begin
            acc     <= {{WIDTH{1'b0}}, in1};
            operand <= in2;
            cnt     <= CNT_W'(WIDTH - 1);
          end
          // The defined divide-by-zero result overrides a same-edge MT write.
          if (div_by_zero) begin
            hi <= '0;
            lo <= '0;
          end
        end
        MUL, DIV: begin
          if (!flush) begin
            acc <= acc_next;
            if (cnt == '0) begin
              {hi, lo} <= acc_next;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: timing, results, flush, reset and
// HI/LO move interactions, each with hand-computed expectations.
module tb_hilo_muldiv_seq;
  import hilo_muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   controle;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         flush;
  logic         mt_hi;
  logic         mt_lo;
  logic [W-1:0] mt_data;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .controle (controle),
    .in1      (in1),
    .in2      (in2),
    .flush    (flush),
    .mt_hi    (mt_hi),
    .mt_lo    (mt_lo),
    .mt_data  (mt_data),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launches an op at the next edge (edge 0) and samples on each falling edge
  // after it; index i is the sample following edge i.
  task automatic run_op(input string tag, input logic [3:0] ctl,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_busy, input int exp_done_idx,
                        input int inject_at, input bit mt_in_done);
    int nbusy    = 0;
    int done_idx = -1;
    @(negedge clock);
    start = 1'b1; controle = ctl; in1 = a; in2 = b;
    @(posedge clock);
    for (int i = 0; i < 40 && done_idx < 0; i++) begin
      @(negedge clock);
      start = 1'b0; mt_hi = 1'b0;
      if (i == inject_at) begin
        start = 1'b1; controle = OP_DIV; mt_hi = 1'b1; mt_data = 32'h0000_DEAD;
      end
      if (busy) nbusy++;
      if (done) done_idx = i;
    end
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
    check({tag, "_done_idx"}, 64'(done_idx), 64'(exp_done_idx));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    start = 1'b0; mt_hi = 1'b0;
    if (mt_in_done) begin
      mt_lo = 1'b1; mt_data = 32'h0000_1234;
    end
    @(negedge clock);
    mt_lo = 1'b0;
    check({tag, "_done_pulse_end"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    if (mt_in_done) begin
      check({tag, "_mt_lo_in_done"}, 64'(lo), 64'h1234);
      check({tag, "_hi_kept"}, 64'(hi), 64'(exp_hi));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; controle = 4'b0000; in1 = '0; in2 = '0;
    flush = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op("mul_7x6", OP_MULT, 32'd7, 32'd6, 32'h0, 32'h2A, 32, 32, -1, 1'b0);
    run_op("mul_max", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 32, 32, -1, 1'b0);
    run_op("mul_msb", OP_MULT, 32'h8000_0000, 32'd2, 32'h1, 32'h0, 32, 32, -1, 1'b0);
    run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 32, 32, -1, 1'b0);
    run_op("div_max_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 32, 32, -1, 1'b0);
    run_op("div_5_9", OP_DIV, 32'd5, 32'd9, 32'd5, 32'd0, 32, 32, -1, 1'b0);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'h0, 32'h0, 0, 0, -1, 1'b0);

    // Busy-time start/MTHI are ignored; MTLO in DONE overwrites the result.
    run_op("mul_interf", OP_MULT, 32'h1234_5678, 32'h10,
           32'h1, 32'h2345_6780, 32, 32, 5, 1'b1);

    // Flush sampled at edge 10 of a MULT 3*3; HI/LO keep 0x1 / 0x1234.
    @(negedge clock);
    start = 1'b1; controle = OP_MULT; in1 = 32'd3; in2 = 32'd3;
    @(posedge clock);
    begin
      int dcount = 0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clock);
        start = 1'b0;
        flush = (i == 9);
        if (i == 10) check("flush_busy_low", 64'(busy), 64'd0);
        if (done) dcount++;
      end
      flush = 1'b0;
      check("flush_no_done", 64'(dcount), 64'd0);
    end
    check("flush_hi_kept", 64'(hi), 64'h1);
    check("flush_lo_kept", 64'(lo), 64'h1234);
    run_op("mul_after_flush", OP_MULT, 32'd3, 32'd3, 32'h0, 32'd9, 32, 32, -1, 1'b0);

    // Synchronous reset at edge 20 of a DIV aborts it and clears HI/LO.
    @(negedge clock);
    start = 1'b1; controle = OP_DIV; in1 = 32'd100; in2 = 32'd7;
    @(posedge clock);
    begin
      int dcount = 0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clock);
        start = 1'b0;
        reset = (i == 19);
        if (i == 20) begin
          check("rst_mid_busy", 64'(busy), 64'd0);
          check("rst_mid_done", 64'(done), 64'd0);
          check("rst_mid_hi", 64'(hi), 64'd0);
          check("rst_mid_lo", 64'(lo), 64'd0);
        end
        if (done) dcount++;
      end
      reset = 1'b0;
      check("rst_mid_no_done", 64'(dcount), 64'd0);
    end

    // Unhonoured control code is ignored; MTHI alone in IDLE lands.
    @(negedge clock);
    start = 1'b1; controle = 4'b0000; in1 = 32'd9; in2 = 32'd9;
    mt_hi = 1'b1; mt_data = 32'hCAFE_0001;
    @(negedge clock);
    start = 1'b0; mt_hi = 1'b0;
    check("bad_op_busy", 64'(busy), 64'd0);
    check("bad_op_done", 64'(done), 64'd0);
    check("mt_hi_idle", 64'(hi), 64'hCAFE_0001);
    check("mt_hi_idle_lo", 64'(lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
